ddr_burst_scheduler: RTL
========================

Name: ddr_burst_scheduler

Overview:
- Sequences the single AXI4 DDR3 master port between the camera write path and the HDMI read path.
- Watches the write-FIFO and read-FIFO fill levels and issues one-cycle wr_trig/rd_trig burst requests to the AXI master, one burst at a time.
- Waits for each burst's completion, applies read-urgency and round-robin arbitration, and limits reads to one frame's worth per video frame.
- Sits between the FIFOs/timing generator and the AXI master controller.

Parameters:
- LVL_W, 10, width of FIFO level inputs.
- WR_THRESH, 16, minimum wfifo level (beats) for a write to be eligible; equals burst length.
- RD_THRESH, 496, maximum rfifo level for a read to be eligible (depth 512 minus 16 beats).
- RD_URGENT, 64, rfifo level below which an eligible read wins unconditionally.
- FRAME_BURSTS, 16200, read bursts per frame (1920*1080*2/256).
- TIMEOUT_CYCLES, 4095, maximum cycles waiting for a completion.

Ports:
- sclk, in, 1, system clock; the only clock.
- s_rst, in, 1, synchronous, active-high reset.
- enable, in, 1, global scheduling enable; 0 blocks new grants only.
- wfifo_rd_cnt, in, LVL_W, beats available in the write FIFO.
- rfifo_wr_cnt, in, LVL_W, beats stored in the read FIFO.
- frame_sync, in, 1, vsync already in the sclk domain; the rising edge marks a frame start.
- wr_trig, out, 1, one-cycle write burst request to the AXI master.
- wr_done, in, 1, write burst complete (B handshake).
- rd_trig, out, 1, one-cycle read burst request to the AXI master.
- rd_done, in, 1, read burst complete (handshake with RLAST).
- busy, out, 1, high when the state is not IDLE.
- rd_frame_done, out, 1, high when FRAME_BURSTS reads have been issued in the current frame.
- timeout_err, out, 1, sticky completion-timeout flag.

Behaviour:
- Reset: all outputs are 0. State is IDLE, rd_frame_cnt=0, tmo_cnt=0, last_grant=RD (so the first tie goes to WR). fs_d is cleared to 0.
- Reset mid-burst returns to IDLE immediately; no trig is issued in the reset cycle.
- Edge detect: fs_rise = frame_sync & ~fs_d, where fs_d is registered every cycle.
- Eligibility, evaluated in IDLE:
  - wr_elig = enable & (wfifo_rd_cnt >= WR_THRESH).
  - rd_elig = enable & (rfifo_wr_cnt <= RD_THRESH) & (rd_frame_cnt < FRAME_BURSTS) & ~fs_rise.
  - rd_urg = rd_elig & (rfifo_wr_cnt < RD_URGENT).
- Arbitration in IDLE, in priority order:
  - If rd_urg, go to RD_ISSUE.
  - Else if both are eligible, grant the opposite of last_grant.
  - Else if only one is eligible, grant it.
  - Else stay in IDLE.
  - last_grant updates on entry to an ISSUE state.
- Trig timing:
  - wr_trig=1 only while in WR_ISSUE; rd_trig=1 only while in RD_ISSUE.
  - Both are registered outputs; they are never high together and each lasts exactly one cycle.
  - ISSUE always moves to the matching WAIT on the next cycle.
- WAIT states:
  - tmo_cnt clears on WAIT entry and increments each WAIT cycle.
  - Matching done -> IDLE on the next cycle.
  - tmo_cnt == TIMEOUT_CYCLES -> set timeout_err and go to IDLE.
  - A done arriving outside its matching WAIT state is ignored.
- Latency: eligible at cycle N in IDLE -> trig high at N+1 -> WAIT at N+2. Done at cycle M -> IDLE at M+1 -> earliest next trig at M+2.
- Frame handling:
  - fs_rise clears rd_frame_cnt and rd_frame_done.
  - fs_rise in RD_ISSUE or RD_WAIT aborts to IDLE without setting timeout_err; the master resets its read side on vsync. In RD_ISSUE, rd_trig is still the registered 1 for that cycle.
  - fs_rise in the WR states has no effect.
  - rd_frame_cnt increments on entry to RD_ISSUE and saturates at FRAME_BURSTS.
  - rd_frame_done = (rd_frame_cnt == FRAME_BURSTS).
  - If fs_rise and an RD_ISSUE entry coincide, the clear wins and rd_frame_cnt=0. This cannot occur in IDLE because rd_elig is masked by fs_rise.
- enable=0 during a WAIT does not abort; the burst completes normally.
- Widths: rd_frame_cnt is 16 bits and tmo_cnt is 16 bits. Level comparisons are unsigned, at LVL_W bits.
- timeout_err clears only on s_rst.

Test Plan:
- After reset, wfifo_rd_cnt=16 and rfifo_wr_cnt=500 -> wr_trig is one pulse 1 cycle later. wr_done after 20 cycles -> IDLE on the next cycle, with a new wr_trig 2 cycles after done.
- Both eligible with rfifo_wr_cnt=200 and done returned 10 cycles after each trig -> grants alternate WR, RD, WR, RD. wr_trig and rd_trig are never high together.
- rfifo_wr_cnt=10 (urgent) with the write eligible -> rd_trig on 3 consecutive grants, no wr_trig.
- Hold the read eligible with FRAME_BURSTS=4 (override) -> exactly 4 rd_trig and rd_frame_done=1, then no further reads. frame_sync rising -> rd_frame_done=0 and reads resume.
- frame_sync rises during RD_WAIT -> IDLE on the next cycle, timeout_err=0, rd_frame_cnt=0.
- Never assert wr_done after a wr_trig with TIMEOUT_CYCLES=8 -> timeout_err=1, state returns to IDLE and the next grant proceeds. Assert s_rst -> timeout_err=0.

Source files
------------

// File: rtl/ddr_burst_scheduler.sv
// Arbitrates the single DDR3 AXI master between the camera write FIFO and the
// HDMI read FIFO, issuing one burst at a time and pacing reads per video frame.
module ddr_burst_scheduler #(
   parameter int LVL_W          = 10,
   parameter int WR_THRESH      = 16,
   parameter int RD_THRESH      = 496,
   parameter int RD_URGENT      = 64,
   parameter int FRAME_BURSTS   = 16200,
   parameter int TIMEOUT_CYCLES = 4095
) (
   input  logic             sclk,
   input  logic             s_rst,
   input  logic             enable,
   input  logic [LVL_W-1:0] wfifo_rd_cnt,
   input  logic [LVL_W-1:0] rfifo_wr_cnt,
   input  logic             frame_sync,
   output logic             wr_trig,
   input  logic             wr_done,
   output logic             rd_trig,
   input  logic             rd_done,
   output logic             busy,
   output logic             rd_frame_done,
   output logic             timeout_err
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WR_ISSUE = 3'd1,
      WR_WAIT  = 3'd2,
      RD_ISSUE = 3'd3,
      RD_WAIT  = 3'd4
   } state_t;

   localparam logic [LVL_W-1:0] WR_LVL    = LVL_W'(WR_THRESH);
   localparam logic [LVL_W-1:0] RD_LVL    = LVL_W'(RD_THRESH);
   localparam logic [LVL_W-1:0] URG_LVL   = LVL_W'(RD_URGENT);
   localparam logic [15:0]      FRAME_MAX = 16'(FRAME_BURSTS);
   localparam logic [15:0]      TMO_MAX   = 16'(TIMEOUT_CYCLES);

   state_t      state_q, state_d;
   logic        fs_q;
   logic        lastRd_q, lastRd_d;
   logic [15:0] rdFrameCnt_q, rdFrameCnt_d;
   logic [15:0] tmoCnt_q, tmoCnt_d;
   logic        timeoutErr_q, timeoutErr_d;

   logic        fsRise;
   logic        wrElig;
   logic        rdElig;
   logic        rdUrg;

   // A read is never granted on the frame-start cycle, so the counter clear cannot race a grant.
   assign fsRise = frame_sync & ~fs_q;
   assign wrElig = enable & (wfifo_rd_cnt >= WR_LVL);
   assign rdElig = enable & (rfifo_wr_cnt <= RD_LVL) & (rdFrameCnt_q < FRAME_MAX) & ~fsRise;
   assign rdUrg  = rdElig & (rfifo_wr_cnt < URG_LVL);

   always_ff @(posedge sclk) begin
      if (s_rst) begin
         state_q      <= IDLE;
         fs_q         <= 1'b0;
         lastRd_q     <= 1'b1;
         rdFrameCnt_q <= 16'd0;
         tmoCnt_q     <= 16'd0;
         timeoutErr_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         fs_q         <= frame_sync;
         lastRd_q     <= lastRd_d;
         rdFrameCnt_q <= rdFrameCnt_d;
         tmoCnt_q     <= tmoCnt_d;
         timeoutErr_q <= timeoutErr_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      lastRd_d     = lastRd_q;
      rdFrameCnt_d = rdFrameCnt_q;
      tmoCnt_d     = tmoCnt_q;
      timeoutErr_d = timeoutErr_q;

      case (state_q)
         IDLE: begin
            if (rdUrg) begin
               state_d = RD_ISSUE;
            end else if (wrElig && rdElig) begin
               state_d = lastRd_q ? WR_ISSUE : RD_ISSUE;
            end else if (wrElig) begin
               state_d = WR_ISSUE;
            end else if (rdElig) begin
               state_d = RD_ISSUE;
            end
         end
         WR_ISSUE: begin
            state_d  = WR_WAIT;
            tmoCnt_d = 16'd0;
         end
         RD_ISSUE: begin
            if (fsRise) begin
               state_d = IDLE;
            end else begin
               state_d  = RD_WAIT;
               tmoCnt_d = 16'd0;
            end
         end
         WR_WAIT: begin
            if (wr_done) begin
               state_d = IDLE;
            end else if (tmoCnt_q == TMO_MAX) begin
               state_d      = IDLE;
               timeoutErr_d = 1'b1;
            end else begin
               tmoCnt_d = tmoCnt_q + 16'd1;
            end
         end
         RD_WAIT: begin
            // The master drops its read side on vsync, so the burst will never complete.
            if (fsRise || rd_done) begin
               state_d = IDLE;
            end else if (tmoCnt_q == TMO_MAX) begin
               state_d      = IDLE;
               timeoutErr_d = 1'b1;
            end else begin
               tmoCnt_d = tmoCnt_q + 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (state_q == IDLE && state_d == WR_ISSUE) begin
         lastRd_d = 1'b0;
      end
      if (state_q == IDLE && state_d == RD_ISSUE) begin
         lastRd_d = 1'b1;
         if (rdFrameCnt_q < FRAME_MAX) begin
            rdFrameCnt_d = rdFrameCnt_q + 16'd1;
         end
      end
      if (fsRise) begin
         rdFrameCnt_d = 16'd0;
      end
   end

   assign wr_trig       = (state_q == WR_ISSUE);
   assign rd_trig       = (state_q == RD_ISSUE);
   assign busy          = (state_q != IDLE);
   assign rd_frame_done = (rdFrameCnt_q == FRAME_MAX);
   assign timeout_err   = timeoutErr_q;

endmodule
